graph_plotter: RTL
==================

Name: graph_plotter

Overview:
- Downstream consumer of the graph generator, which presents 64 points (32-bit xs/ys arrays) and raises `complete` when they are valid.
- On a rising edge of `start` (tied to `complete`), walks points 0..N_POINTS-1 in order and rasterises the polyline P0→P1→…→P(N-1) with Bresenham.
- Emits one screen pixel per transfer on a valid/ready write stream into the framebuffer writer.

Parameters:
- N_POINTS, 64, number of points; index width is clog2(N_POINTS).
- COORD_W, 32, signed width of the point coordinates.
- SCR_W, 640, screen width in pixels.
- SCR_H, 480, screen height in pixels.
- PX_W, 10, width of pix_x.
- PY_W, 9, width of pix_y.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  level from graph `complete`; edge-detected internally
- pt_idx  out  6  registered point index driven to graph's xs/ys read mux
- pt_x  in  COORD_W  signed xs[pt_idx], sampled the cycle after pt_idx updates
- pt_y  in  COORD_W  signed ys[pt_idx], same timing as pt_x
- pix_valid  out  1  pixel available
- pix_ready  in  1  framebuffer writer accepts pixel
- pix_x  out  PX_W  pixel column
- pix_y  out  PY_W  pixel row
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after the final pixel transfers

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: all outputs 0; start-edge register 0; state IDLE.
- Reset mid-operation: on the next edge the block returns to IDLE, pix_valid=0, busy=0, and no done pulse is produced.
- Start: the start edge is start=1 while the previous sample was 0. It is accepted only in IDLE. Edges while busy are ignored, and a level held high does not retrigger.
- Clamping on capture: x saturates to [0, SCR_W-1] and y to [0, SCR_H-1], using signed compare. Internal Bresenham uses 12-bit signed coordinates and a 13-bit signed err.
- States:
  - IDLE: wait for the start edge.
  - FETCH_A: pt_idx←0.
  - LOAD_A: capture P0, pt_idx←1.
  - LOAD_B: capture P(i+1).
  - SETUP: dx=|x1-x0|, dy=-|y1-y0|, sx/sy=±1, err=dx+dy, cur=(x0,y0).
  - DRAW: emit pixels for the segment.
  - ADV: move to the next segment or finish.
  - DONE: done=1 for one cycle, then IDLE.
- Latency: with the start edge sampled at edge E0, states advance FETCH_A@E0, LOAD_A@E1, LOAD_B@E2, SETUP@E3. pix_valid is first high after E4, presenting P0.
- DRAW:
  - pix_x/pix_y=cur while pix_valid=1. These values must not change while pix_valid=1 and pix_ready=0.
  - On a transfer, e2=2·err. If e2≥dy then err+=dy and x+=sx; if e2≤dx then err+=dx and y+=sy. Both updates apply in the same step.
- Endpoint rule:
  - Segments 0..N-3 emit start through end exclusive.
  - The last segment (P(N-2)→P(N-1)) also emits its end pixel.
  - A zero-length non-final segment emits nothing and goes straight to ADV.
  - When cur reaches the end of a non-final segment, pix_valid drops.
- ADV (non-final segment): P(i+1) becomes the new start, pt_idx←i+2, then LOAD_B → SETUP → DRAW. This gives a fixed 3-cycle pix_valid gap between segments.
- ADV (final segment): go to DONE.
- busy: 1 from E0 through the DONE cycle inclusive.
- pix_ready: may be held 0 indefinitely with no data loss. pix_valid never drops without a transfer, except under reset.

Test Plan:
- Horizontal line: x_i=10·i, y_i=100; pulse complete → 631 pixels (x=0..630, y=100) in order, no duplicates; done pulses once; busy is 0 afterwards.
- Backpressure: same points with pix_ready alternating 1,0 each cycle plus a random 20-cycle stall → identical 631-pixel sequence; pix_x/pix_y stable during every stall.
- Steep diagonal: P_i=(i,3i) → 190 pixels with y=0..189 each exactly once; x is monotonic and changes by at most 1 per pixel; last pixel is (63,189).
- Clamping and degenerate cases:
  - All points at (-50,1000) → exactly 1 pixel, (0,479).
  - All points at (5,5) → exactly 1 pixel, (5,5).
- Reset mid-draw: assert rst for one cycle after the 200th transfer of the horizontal test → next cycle pix_valid=0, busy=0, no done. A fresh start edge then reproduces the full 631 pixels.
- Start filtering: hold start high through the entire run and toggle it during DRAW → exactly one run and one done; a new edge after IDLE starts a second full run.

Source files
------------

// File: rtl/graph_plotter.sv
// graph_plotter: rasterises the polyline P0->P1->...->P(N-1) with Bresenham into a pixel write stream.
// Latency: start edge sampled at E0, first pixel valid after E4; 3-cycle pix_valid gap between segments.
// Backpressure: pixel held stable while o_pix_valid && !o_pix_ready... i.e. until i_pix_ready; stalls indefinitely without loss.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start             level from the graph generator's `complete`; rising edge starts a run from IDLE
//   o_pt_idx            registered index into the generator's xs/ys read mux
//   i_pt_x, i_pt_y      signed point coordinates for o_pt_idx, sampled one cycle after o_pt_idx changes
//   o_pix_valid/_ready  pixel write stream handshake
//   o_pix_x, o_pix_y    pixel column / row
//   o_busy              high from start acceptance through the DONE cycle
//   o_done              one-cycle pulse after the final pixel transfers
module graph_plotter #(
  parameter int N_POINTS = 64,
  parameter int COORD_W  = 32,
  parameter int SCR_W    = 640,
  parameter int SCR_H    = 480,
  parameter int PX_W     = 10,
  parameter int PY_W     = 9,
  localparam int IDX_W   = $clog2(N_POINTS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  output logic [IDX_W-1:0]          o_pt_idx,
  input  logic signed [COORD_W-1:0] i_pt_x,
  input  logic signed [COORD_W-1:0] i_pt_y,
  output logic                      o_pix_valid,
  input  logic                      i_pix_ready,
  output logic [PX_W-1:0]           o_pix_x,
  output logic [PY_W-1:0]           o_pix_y,
  output logic                      o_busy,
  output logic                      o_done
);

  // Internal Bresenham arithmetic: 12-bit signed coordinates, 13-bit signed error term.
  localparam int CW = 12;
  localparam int EW = 13;

  localparam logic [IDX_W-1:0]          LAST_IDX = IDX_W'(N_POINTS - 1);
  localparam logic signed [COORD_W-1:0] X_MAX    = COORD_W'(SCR_W - 1);
  localparam logic signed [COORD_W-1:0] Y_MAX    = COORD_W'(SCR_H - 1);
  localparam logic signed [CW-1:0]      ONE      = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_A,
    S_LOAD_A,
    S_LOAD_B,
    S_SETUP,
    S_DRAW,
    S_ADV,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                 r_start_d;
  logic [IDX_W-1:0]     r_pt_idx;

  // Segment start (x0,y0), end (x1,y1) and current pixel (cx,cy), all already clamped.
  logic signed [CW-1:0] r_x0, r_y0;
  logic signed [CW-1:0] r_x1, r_y1;
  logic signed [CW-1:0] r_cx, r_cy;
  logic signed [CW-1:0] r_dx;      // |x1-x0|
  logic signed [CW-1:0] r_dy;      // -|y1-y0|
  logic                 r_sx_neg;  // x steps by -1 when set, else +1
  logic                 r_sy_neg;
  logic signed [EW-1:0] r_err;

  // Saturate a signed coordinate into [0, hi]; the in-range value always fits in CW bits.
  function automatic logic signed [CW-1:0] clamp(input logic signed [COORD_W-1:0] v,
                                                 input logic signed [COORD_W-1:0] hi);
    if (v[COORD_W-1])
      return '0;
    else if (v > hi)
      return hi[CW-1:0];
    else
      return v[CW-1:0];
  endfunction

  logic                 w_start_edge;
  logic                 w_last_seg;
  logic                 w_zero_seg;
  logic signed [CW-1:0] w_ddx, w_ddy;
  logic signed [CW-1:0] w_adx, w_ady;
  logic signed [EW:0]   w_e2;
  logic signed [EW:0]   w_dx_w, w_dy_w;
  logic                 w_step_x, w_step_y;
  logic signed [CW-1:0] w_nx, w_ny;
  logic signed [EW-1:0] w_nerr;
  logic                 w_at_end;
  logic                 w_next_end;
  logic                 w_unused;

  assign w_start_edge = i_start & ~r_start_d;

  // While a segment is set up or drawn, o_pt_idx points at its end point, so the
  // final segment is the one whose end index is N_POINTS-1.
  assign w_last_seg = (r_pt_idx == LAST_IDX);

  assign w_ddx      = r_x1 - r_x0;
  assign w_ddy      = r_y1 - r_y0;
  assign w_adx      = w_ddx[CW-1] ? -w_ddx : w_ddx;
  assign w_ady      = w_ddy[CW-1] ? -w_ddy : w_ddy;
  assign w_zero_seg = (r_x0 == r_x1) && (r_y0 == r_y1);

  // e2 = 2*err needs one extra bit over err.
  assign w_e2     = {r_err, 1'b0};
  assign w_dx_w   = {{(EW + 1 - CW){r_dx[CW-1]}}, r_dx};
  assign w_dy_w   = {{(EW + 1 - CW){r_dy[CW-1]}}, r_dy};
  assign w_step_x = (w_e2 >= w_dy_w);
  assign w_step_y = (w_e2 <= w_dx_w);

  assign w_nx = w_step_x ? (r_sx_neg ? r_cx - ONE : r_cx + ONE) : r_cx;
  assign w_ny = w_step_y ? (r_sy_neg ? r_cy - ONE : r_cy + ONE) : r_cy;

  // Both error contributions apply in the same step.
  assign w_nerr = r_err
                + (w_step_x ? w_dy_w[EW-1:0] : '0)
                + (w_step_y ? w_dx_w[EW-1:0] : '0);

  assign w_at_end   = (r_cx == r_x1) && (r_cy == r_y1);
  assign w_next_end = (w_nx == r_x1) && (w_ny == r_y1);

  // Upper coordinate bits are always zero after clamping; only the screen-width slice is driven out.
  assign w_unused = ^{r_cx[CW-1:PX_W], r_cy[CW-1:PY_W]};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_start_edge) w_state_nxt = S_FETCH_A;
      S_FETCH_A: w_state_nxt = S_LOAD_A;
      S_LOAD_A:  w_state_nxt = S_LOAD_B;
      S_LOAD_B:  w_state_nxt = S_SETUP;
      // A zero-length intermediate segment has nothing to emit.
      S_SETUP:   w_state_nxt = (w_zero_seg && !w_last_seg) ? S_ADV : S_DRAW;
      S_DRAW: begin
        if (i_pix_ready) begin
          if (w_last_seg) begin
            // The final segment emits its end pixel too.
            if (w_at_end) w_state_nxt = S_DONE;
          end else if (w_next_end) begin
            // Leave as soon as the end pixel would be next: it belongs to the following segment.
            w_state_nxt = S_ADV;
          end
        end
      end
      S_ADV:     w_state_nxt = w_last_seg ? S_DONE : S_LOAD_B;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    o_pix_valid = (r_state == S_DRAW);
    o_busy      = (r_state != S_IDLE);
    o_done      = (r_state == S_DONE);
  end

  assign o_pt_idx = r_pt_idx;
  assign o_pix_x  = r_cx[PX_W-1:0];
  assign o_pix_y  = r_cy[PY_W-1:0];

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_start_d <= 1'b0;
      r_pt_idx  <= '0;
      r_x0      <= '0;
      r_y0      <= '0;
      r_x1      <= '0;
      r_y1      <= '0;
      r_cx      <= '0;
      r_cy      <= '0;
      r_dx      <= '0;
      r_dy      <= '0;
      r_sx_neg  <= 1'b0;
      r_sy_neg  <= 1'b0;
      r_err     <= '0;
    end else begin
      r_start_d <= i_start;
      case (r_state)
        S_FETCH_A: r_pt_idx <= '0;
        S_LOAD_A: begin
          r_x0     <= clamp(i_pt_x, X_MAX);
          r_y0     <= clamp(i_pt_y, Y_MAX);
          r_pt_idx <= IDX_W'(1);
        end
        S_LOAD_B: begin
          r_x1 <= clamp(i_pt_x, X_MAX);
          r_y1 <= clamp(i_pt_y, Y_MAX);
        end
        S_SETUP: begin
          r_dx     <= w_adx;
          r_dy     <= -w_ady;
          r_sx_neg <= !(r_x0 < r_x1);
          r_sy_neg <= !(r_y0 < r_y1);
          r_err    <= {{(EW - CW){w_adx[CW-1]}}, w_adx} - {{(EW - CW){w_ady[CW-1]}}, w_ady};
          r_cx     <= r_x0;
          r_cy     <= r_y0;
        end
        S_DRAW: begin
          // Hold cur on the final pixel so the output stays put after the last transfer.
          if (i_pix_ready && !(w_last_seg && w_at_end)) begin
            r_cx  <= w_nx;
            r_cy  <= w_ny;
            r_err <= w_nerr;
          end
        end
        S_ADV: begin
          r_x0     <= r_x1;
          r_y0     <= r_y1;
          r_pt_idx <= r_pt_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
